// File: rtl/mux_display.sv
// rtl/mux_display.sv - four-digit seven-segment scan driver with guard blanking and frame snapshot
module mux_display #(
  parameter int DIGITS       = 4,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                lz_blank,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg,
  output logic                dp
);

  localparam int              IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(DIGITS - 1);
  localparam logic [7:0]      GUARD    = 8'(BLANK_CYCLES);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t              state, state_nx;
  logic [IW-1:0]       idx, idx_nx;
  logic [7:0]          cnt, cnt_nx;
  logic                enable_q;
  logic                tick;
  logic                snap_en;
  logic [4*DIGITS-1:0] snap_data;
  logic [DIGITS-1:0]   snap_dp;
  logic [DIGITS-1:0]   lz_mask;
  logic [3:0]          nibble;
  logic [6:0]          seg_d;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  assign tick = enable & ~enable_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= BLANK;
      idx       <= '0;
      cnt       <= GUARD;
      enable_q  <= 1'b0;
      snap_data <= '0;
      snap_dp   <= '0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      cnt      <= cnt_nx;
      enable_q <= enable;
      if (snap_en) begin
        snap_data <= data;
        snap_dp   <= dp_in;
      end
    end
  end

  // A tick always wins, even on the edge where the guard would have expired.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    snap_en  = 1'b0;
    if (tick) begin
      idx_nx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      state_nx = BLANK;
      cnt_nx   = GUARD;
    end else if (state == BLANK) begin
      if (cnt == 8'd1) begin
        state_nx = DRIVE;
        snap_en  = (idx == '0);
      end else begin
        cnt_nx = cnt - 8'd1;
      end
    end
  end

  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_mask    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (snap_data[4*i +: 4] == 4'd0);
      lz_mask[i] = lz_blank & upper_zero & (i != 0);
    end
  end

  assign nibble = snap_data[4*idx +: 4];
  assign seg_d  = lz_mask[idx] ? 7'h7F : decode(nibble);

  // Segment data is captured only on the first drive cycle so it stays frozen while the anode is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (state == BLANK) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (an == '1) begin
      an  <= ~(DIGITS'(1) << idx);
      seg <= seg_d;
      dp  <= ~snap_dp[idx];
    end
  end

endmodule

// File: tb/tb_mux_display.sv
// tb/tb_mux_display.sv - randomized and directed bench for mux_display against a schedule-based model
module tb_mux_display;

  localparam int DIGITS = 4;
  localparam int B      = 8;
  localparam logic [11:0] OFF = 12'hFFF;
  localparam logic [6:0] SEG_LUT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        enable   = 1'b0;
  logic [15:0] data     = 16'h1234;
  logic [3:0]  dp_in    = 4'b0000;
  logic        lz_blank = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_display #(.DIGITS(DIGITS), .BLANK_CYCLES(B)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .data     (data),
    .dp_in    (dp_in),
    .lz_blank (lz_blank),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] disp(input int d, input logic [15:0] s, input logic [3:0] sdp,
                                       input logic lz);
    logic [15:0] upper;
    logic [3:0]  a;
    logic [6:0]  sg;
    upper = s >> (4 * d);
    a     = 4'hF ^ (4'b0001 << d);
    sg    = (lz && d > 0 && upper == 16'd0) ? 7'h7F : SEG_LUT[upper[3:0]];
    return {a, sg, ~sdp[d]};
  endfunction

  // Model: a digit becomes visible at an absolute cycle number; ticks and resets reschedule it.
  int          cyc = 0;
  int          m_digit = 0;
  int          m_show_at = 1000000;
  bit          m_en_prev = 1'b0;
  logic [15:0] m_snap = '0;
  logic [3:0]  m_snap_dp = '0;
  logic [11:0] m_disp = OFF;

  always @(posedge clk) begin : model
    logic [11:0] e;
    bit          tk;
    cyc++;
    if (!rst) begin
      e         = OFF;
      m_digit   = 0;
      m_show_at = cyc + 1 + B;
      m_en_prev = 1'b0;
      m_snap    = '0;
      m_snap_dp = '0;
    end else begin
      if (cyc == m_show_at) m_disp = disp(m_digit, m_snap, m_snap_dp, lz_blank);
      e  = (cyc >= m_show_at) ? m_disp : OFF;
      tk = enable && !m_en_prev;
      m_en_prev = enable;
      if (tk) begin
        m_digit   = (m_digit + 1) % DIGITS;
        m_show_at = cyc + 1 + B;
      end else if (cyc == m_show_at - 1 && m_digit == 0) begin
        m_snap    = data;
        m_snap_dp = dp_in;
      end
    end
    #1 check("scan", {20'd0, an, seg, dp}, {20'd0, e});
  end

  task automatic expect_digit(input string tag, input logic [3:0] ean, input logic [6:0] eseg,
                              input logic edp);
    int n;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (an != 4'hF) break;
      n++;
    end
    check({tag, "_guard"}, n, B);
    check({tag, "_an"}, ean, ean == an ? ean : an);
    check({tag, "_seg"}, seg, eseg);
    check({tag, "_dp"}, dp, edp);
  endtask

  task automatic step(input string tag, input bit glitch, input logic [3:0] ean,
                      input logic [6:0] eseg, input logic edp);
    @(negedge clk) enable = 1'b1;
    @(negedge clk) enable = 1'b0;
    if (glitch) begin
      @(negedge clk) enable = 1'b1;
      @(negedge clk) enable = 1'b0;
    end
    expect_digit(tag, ean, eseg, edp);
    repeat ($urandom_range(0, 6)) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    rst = 1'b1;
    expect_digit("release", 4'hE, 7'h19, 1'b1);

    step("scan1", 0, 4'hD, 7'h30, 1'b1);
    step("scan2", 0, 4'hB, 7'h24, 1'b1);
    step("scan3", 0, 4'h7, 7'h79, 1'b1);
    step("scan0", 0, 4'hE, 7'h19, 1'b1);

    data = 16'h0042; lz_blank = 1'b1;
    step("lzpre1", 0, 4'hD, 7'h30, 1'b1);
    step("lzpre2", 0, 4'hB, 7'h24, 1'b1);
    step("lzpre3", 0, 4'h7, 7'h79, 1'b1);
    step("lzpre0", 0, 4'hE, 7'h24, 1'b1);
    step("lz1", 0, 4'hD, 7'h19, 1'b1);
    step("lz2", 0, 4'hB, 7'h7F, 1'b1);
    step("lz3", 0, 4'h7, 7'h7F, 1'b1);
    step("lz0", 0, 4'hE, 7'h24, 1'b1);
    lz_blank = 1'b0;
    step("nolz1", 0, 4'hD, 7'h19, 1'b1);
    step("nolz2", 0, 4'hB, 7'h40, 1'b1);
    step("nolz3", 0, 4'h7, 7'h40, 1'b1);
    step("nolz0", 0, 4'hE, 7'h24, 1'b1);

    data = 16'h1234;
    step("snpre1", 0, 4'hD, 7'h19, 1'b1);
    step("snpre2", 0, 4'hB, 7'h40, 1'b1);
    step("snpre3", 0, 4'h7, 7'h40, 1'b1);
    step("snpre0", 0, 4'hE, 7'h19, 1'b1);
    step("snap1", 0, 4'hD, 7'h30, 1'b1);
    step("snap2", 0, 4'hB, 7'h24, 1'b1);
    data = 16'hABCD;
    step("snap3", 0, 4'h7, 7'h79, 1'b1);
    step("snap0", 0, 4'hE, 7'h21, 1'b1);

    dp_in = 4'b0100;
    step("dppre1", 0, 4'hD, 7'h46, 1'b1);
    step("dppre2", 0, 4'hB, 7'h03, 1'b1);
    step("dppre3", 0, 4'h7, 7'h08, 1'b1);
    step("dppre0", 0, 4'hE, 7'h21, 1'b1);
    step("glitch", 1, 4'hB, 7'h03, 1'b0);
    step("post3", 0, 4'h7, 7'h08, 1'b1);
    step("post0", 0, 4'hE, 7'h21, 1'b1);
    step("post1", 0, 4'hD, 7'h46, 1'b1);
    step("post2", 0, 4'hB, 7'h03, 1'b0);

    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("mrst_an", an, 4'hF);
    check("mrst_seg", seg, 7'h7F);
    rst = 1'b1;
    expect_digit("mrst", 4'hE, 7'h21, 1'b1);

    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) data = 16'($urandom);
      if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 9) == 0) lz_blank = 1'($urandom);
      if ($urandom_range(0, 3) == 0) data = data & 16'h00FF;
      enable = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 59) != 0);
      repeat ($urandom_range(0, 11)) @(negedge clk);
    end
    @(negedge clk) rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_display.md
# mux_display

Four-digit seven-segment scan driver, directly downstream of the display-rate divider. Consumes the divider's square-wave `enable` output (240 Hz rising edges at default settings) and advances one digit per rising edge, for a 60 Hz per-digit refresh. Each digit is preceded by a short all-off guard interval to suppress ghosting. Data is snapshotted once per full scan, so a digit never mixes old and new values mid-frame.

## Interface
Parameters:
- `DIGITS`, 4, number of digits scanned; data width is 4*DIGITS.
- `BLANK_CYCLES`, 8, guard interval in clk cycles with all anodes off before each digit; legal range 1..255.

Ports:
- `clk` in 1: single clock for all logic (10 MHz system clock).
- `rst` in 1: synchronous, active-low reset.
- `enable` in 1: square wave from the divider, same clock domain. Only its rising edge is used.
- `data` in 4*DIGITS: hex nibbles. Nibble i (`data[4i+3:4i]`) drives digit i; digit 0 is the rightmost (LSD).
- `dp_in` in DIGITS: decimal point per digit, 1 = lit.
- `lz_blank` in 1: 1 = blank leading zeros.
- `an` out DIGITS: anode selects, active-low, one-hot-low when driving.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, active-low.

## Operation
- Edge detect:
  - `enable` is registered into `enable_q`.
  - tick = `enable & ~enable_q`.
  - No synchronizer is used; `enable` is already in the clk domain.
- State: digit index `idx` (0..DIGITS-1), FSM {BLANK, DRIVE}, guard counter (8 bits), snapshot registers `snap_data` and `snap_dp`.
- BLANK:
  - `an` = all ones, `seg` = 7'h7F, `dp` = 1.
  - Counter decrements each cycle.
  - When the counter reaches 1 at a clock edge, the FSM moves to DRIVE at that edge.
- DRIVE:
  - `an[idx]` = 0 and all other anodes 1.
  - `seg` = decode(`snap_data` nibble `idx`) or 7'h7F if the digit is blanked.
  - `dp` = ~`snap_dp[idx]`.
  - Holds until a tick.
- Tick (in either state):
  - `idx` <= (`idx` == DIGITS-1) ? 0 : `idx`+1.
  - FSM <= BLANK, counter <= BLANK_CYCLES.
  - A tick during BLANK restarts the guard and advances `idx` again; no digit is skipped from the wrap order.
- Snapshot: `snap_data` <= `data` and `snap_dp` <= `dp_in` on the BLANK→DRIVE transition when `idx` == 0. Digits 1..DIGITS-1 use that snapshot.
- Leading-zero blanking:
  - Digit i > 0 is blanked when `lz_blank` = 1 and snapshot nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit still drives its anode, and its `dp` follows `snap_dp`.
- Decode (active-low, gfedcba):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (hex).
- Reset (`rst` = 0 at a clk edge):
  - `idx` = 0, FSM = BLANK, counter = BLANK_CYCLES, `enable_q` = 0, snapshots = 0.
  - Outputs: `an` = all ones, `seg` = 7'h7F, `dp` = 1.
  - Reset takes priority over tick.
  - After release, digit 0 is driven BLANK_CYCLES cycles later with a fresh snapshot, without waiting for a tick.
- If `enable` is held high, only one tick is produced.

## Timing
- All outputs are registered.
- Tick latency: if `enable` is sampled 1 at edge k with `enable_q` = 0, then `an` = all ones after edge k+1.
- Guard: `an[idx]` falls and `seg`/`dp` become valid at edge k+1+BLANK_CYCLES, all in the same cycle.
- `seg` and `dp` never change while any anode is low, except at a transition into BLANK, where all outputs go inactive together.
- Snapshot latency: a `data` change is visible from the next digit-0 DRIVE entry onward.
- Default scan rates: 240 digit changes/s; full frame 60 Hz.

## Test plan
- Reset: hold `rst` = 0 for 3 cycles, `enable` = 0 → `an` = 4'b1111, `seg` = 7'h7F, `dp` = 1. With `data` = 16'h1234, 8 cycles after release → `an` = 4'b1110, `seg` = 7'h19.
- Scan order: `data` = 16'h1234; drive 4 `enable` rising edges → `an`/`seg` sequence 1101/30, 1011/24, 0111/79, 1110/19. Each new digit is preceded by exactly 8 cycles of `an` = 1111.
- Leading zeros: `data` = 16'h0042, `lz_blank` = 1 → digits 3 and 2 show `seg` = 7'h7F with anode low; digit 1 shows 7'h19, digit 0 shows 7'h24. With `lz_blank` = 0 → digits 3 and 2 show 7'h40.
- Snapshot: change `data` from 16'h1234 to 16'hABCD while digit 2 is driven → digits 3 and 0 of the current frame still show 1 and 4. The next frame shows 16'hABCD (digit 0 = 7'h21).
- Glitch tick: pulse `enable` 1-0-1 so two rising edges fall within one BLANK window → `idx` advances by 2, the guard restarts at 8, and no anode is asserted early. `dp_in` = 4'b0100 → `dp` = 0 only while `an` = 1011.
- Mid-operation reset: assert `rst` = 0 for one cycle while digit 2 is driven → outputs are inactive after that edge, and digit 0 is driven 8 cycles after release.
